// File: rtl/intersection_arbiter.sv
// Four-way traffic light arbiter: round-robin green grant with min/max green, yellow and all-red clearance.
// All outputs registered; the phase, owner and lights change on the same edge.
module intersection_arbiter #(
    parameter int MIN_GREEN = 8,
    parameter int MAX_GREEN = 32,
    parameter int YELLOW    = 4,
    parameter int ALL_RED   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    output logic [11:0] lights,
    output logic [1:0]  owner,
    output logic [1:0]  phase
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GREEN   = 2'd1,
        S_YELLOW  = 2'd2,
        S_ALL_RED = 2'd3
    } state_t;

    localparam int CW = $clog2(MAX_GREEN + YELLOW + ALL_RED + 1);
    localparam logic [CW-1:0] C_MIN = CW'(MIN_GREEN - 1);
    localparam logic [CW-1:0] C_MAX = CW'(MAX_GREEN - 1);
    localparam logic [CW-1:0] C_YEL = CW'(YELLOW - 1);
    localparam logic [CW-1:0] C_AR  = CW'(ALL_RED - 1);
    localparam logic [11:0]   LIGHTS_ALL_RED = 12'h249;

    state_t          r_state;
    logic [1:0]      r_owner;
    logic [CW-1:0]   r_cnt;
    logic [11:0]     r_lights;

    state_t          w_next_state;
    logic [1:0]      w_next_owner;
    logic [1:0]      w_rr_owner;
    logic [3:0]      w_owner_mask;
    logic            w_others;
    logic            w_any_req;

    // Search owner+1 first; the loop runs from lowest to highest priority so the last hit wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] cur, input logic [3:0] r);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = cur;
        for (int k = 4; k >= 1; k--) begin
            idx = cur + 2'(k);
            if (r[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    function automatic logic [11:0] lights_for(input state_t s, input logic [1:0] o);
        logic [11:0] l;
        l = LIGHTS_ALL_RED;
        for (int i = 0; i < 4; i++) begin
            if (2'(i) == o) begin
                if (s == S_GREEN) begin
                    l[3*i +: 3] = 3'b100;
                end else if (s == S_YELLOW) begin
                    l[3*i +: 3] = 3'b010;
                end
            end
        end
        return l;
    endfunction

    assign w_owner_mask = 4'b0001 << r_owner;
    assign w_others     = |(req & ~w_owner_mask);
    assign w_any_req    = |req;
    assign w_rr_owner   = rr_pick(r_owner, req);

    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_next_state = S_GREEN;
                    w_next_owner = w_rr_owner;
                end
            end
            S_GREEN: begin
                if (w_others && ((!req[r_owner] && (r_cnt >= C_MIN)) || (r_cnt == C_MAX))) begin
                    w_next_state = S_YELLOW;
                end
            end
            S_YELLOW: begin
                if (r_cnt == C_YEL) begin
                    w_next_state = S_ALL_RED;
                end
            end
            S_ALL_RED: begin
                if (r_cnt == C_AR) begin
                    if (w_any_req) begin
                        w_next_state = S_GREEN;
                        w_next_owner = w_rr_owner;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Lights are derived from the next state so they land on the same edge as phase and owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_owner  <= 2'd3;
            r_cnt    <= '0;
            r_lights <= LIGHTS_ALL_RED;
        end else begin
            r_state  <= w_next_state;
            r_owner  <= w_next_owner;
            r_lights <= lights_for(w_next_state, w_next_owner);
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != C_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign lights = r_lights;
    assign owner  = r_owner;
    assign phase  = r_state;

endmodule
